// File: rtl/param_stack_pkg.sv
// Shared types and helpers for the parametrised operand stack.
// The fill-plan helper is width-agnostic: it works on 32-bit values and
// folds the result down to DEPTH_LOG2+1 bits itself.
package param_stack_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL0,
    ST_FILL1
  } state_t;

  typedef struct packed {
    logic [31:0] nd;     // new depth, wrapped modulo 2^(dlog2+1)
    logic        fill0;  // top_0 must be refilled from RAM[nd-1]
    logic        fill1;  // top_1 must be refilled from RAM[nd-2]
    logic        zero0;  // top_0 slot does not exist (nd < 1)
    logic        zero1;  // top_1 slot does not exist (nd < 2)
    logic        udf;    // k > d
    logic        ovf;    // nd > DEPTH (unwrapped)
  } plan_t;

  function automatic plan_t calc_plan(input logic [31:0] d, input logic [31:0] k,
                                      input logic push, input int unsigned dlog2);
    plan_t       p;
    logic [31:0] raw;
    logic [31:0] mask;
    raw     = d - k + {31'd0, push};
    mask    = (32'd1 << (dlog2 + 1)) - 32'd1;
    p.nd    = raw & mask;
    p.udf   = k > d;
    p.ovf   = !p.udf && (raw > (32'd1 << dlog2));
    p.zero0 = p.nd < 32'd1;
    p.zero1 = p.nd < 32'd2;
    p.fill0 = (k >= 32'd2) && !push && !p.zero0;
    p.fill1 = (k != 32'd0) && !p.zero1;
    return p;
  endfunction

endpackage

// File: rtl/param_stack_if.sv
// Operation handshake and status bundle between decode/execute and the stack.
interface param_stack_if #(
  parameter int WIDTH      = 35,
  parameter int DEPTH_LOG2 = 11
);
  logic                  op_valid;
  logic                  op_ready;
  logic                  op_push;
  logic [DEPTH_LOG2-1:0] op_pop_cnt;
  logic [WIDTH-1:0]      op_data;
  logic [WIDTH-1:0]      top_0;
  logic [WIDTH-1:0]      top_1;
  logic [DEPTH_LOG2:0]   depth;
  logic                  empty;
  logic                  full;
  logic                  err_ovf;
  logic                  err_udf;

  modport master (
    output op_valid, op_push, op_pop_cnt, op_data,
    input  op_ready, top_0, top_1, depth, empty, full, err_ovf, err_udf
  );

  modport slave (
    input  op_valid, op_push, op_pop_cnt, op_data,
    output op_ready, top_0, top_1, depth, empty, full, err_ovf, err_udf
  );
endinterface

// File: rtl/param_stack_ram.sv
// 1W1R synchronous RAM, WIDTH x 2^DEPTH_LOG2, registered read output.
// Contents are not reset.
module param_stack_ram #(
  parameter int WIDTH      = 35,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/param_stack.sv
// Parametrised operand stack: top two entries cached in registers, the rest
// in a synchronous RAM (write-through on push).
// Optional overflow/underflow guarding: define PARAM_STACK_GUARD_EN.
module param_stack
  import param_stack_pkg::*;
#(
  parameter int WIDTH      = 35,
  parameter int DEPTH_LOG2 = 11
) (
  input  logic         clk,
  input  logic         rst_b,
  param_stack_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   D_ONE = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   D_TWO = (DEPTH_LOG2+1)'(2);
  localparam logic [DEPTH_LOG2:0]   D_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] A_ONE = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2-1:0] A_TWO = DEPTH_LOG2'(2);

  state_t                state;
  logic [DEPTH_LOG2:0]   depth_q;
  logic [WIDTH-1:0]      top0_q;
  logic [WIDTH-1:0]      top1_q;
  logic [WIDTH-1:0]      rd_data;
  plan_t                 plan;
  logic [DEPTH_LOG2:0]   nd;
  logic                  accept;
  logic                  blocked;
  logic                  k_zero;
  logic                  k_one;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;

  // Decode the offered operation into new depth and fill plan
  always_comb begin
    plan   = calc_plan(32'(depth_q), 32'(bus.op_pop_cnt), bus.op_push, DEPTH_LOG2);
    nd     = plan.nd[DEPTH_LOG2:0];
    accept = bus.op_valid && (state == ST_IDLE);
    k_zero = (bus.op_pop_cnt == '0);
    k_one  = (bus.op_pop_cnt == A_ONE);
  end

`ifdef PARAM_STACK_GUARD_EN
  logic err_ovf_q;
  logic err_udf_q;

  assign blocked     = plan.udf | plan.ovf;
  assign bus.err_ovf = err_ovf_q;
  assign bus.err_udf = err_udf_q;

  // Sticky guard errors, cleared only by reset
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else if (accept) begin
      if (plan.ovf) err_ovf_q <= 1'b1;
      if (plan.udf) err_udf_q <= 1'b1;
    end
  end
`else
  assign blocked     = 1'b0;
  assign bus.err_ovf = 1'b0;
  assign bus.err_udf = 1'b0;
`endif

  // RAM addressing. The read for the first fill is issued at the accept edge
  // (and the second during FILL0) so the registered RAM output is ready
  // exactly when the FILL state consumes it: one cycle per missing top.
  always_comb begin
    wr_en   = accept && bus.op_push && !blocked;
    wr_addr = nd[DEPTH_LOG2-1:0] - A_ONE;
    if (state == ST_FILL0)
      rd_addr = depth_q[DEPTH_LOG2-1:0] - A_TWO;
    else if (plan.fill0)
      rd_addr = nd[DEPTH_LOG2-1:0] - A_ONE;
    else
      rd_addr = nd[DEPTH_LOG2-1:0] - A_TWO;
  end

  param_stack_ram #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.op_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Control FSM: depth/cache update on accept, then refill missing tops
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state   <= ST_IDLE;
      depth_q <= '0;
      top0_q  <= '0;
      top1_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && !blocked) begin
            depth_q <= nd;
            if (k_zero) begin
              if (bus.op_push) begin
                top0_q <= plan.zero0 ? '0 : bus.op_data;
                top1_q <= plan.zero1 ? '0 : top0_q;
              end
            end else begin
              if (plan.zero0)       top0_q <= '0;
              else if (bus.op_push) top0_q <= bus.op_data;
              else if (k_one)       top0_q <= top1_q;
              if (plan.zero1)       top1_q <= '0;
              if (plan.fill0)       state  <= ST_FILL0;
              else if (plan.fill1)  state  <= ST_FILL1;
            end
          end
        end
        ST_FILL0: begin
          top0_q <= rd_data;
          state  <= (depth_q > D_ONE) ? ST_FILL1 : ST_IDLE;
        end
        ST_FILL1: begin
          top1_q <= rd_data;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.op_ready = (state == ST_IDLE);
  assign bus.top_0    = top0_q;
  assign bus.top_1    = top1_q;
  assign bus.depth    = depth_q;
  assign bus.empty    = (depth_q == '0);
  assign bus.full     = (depth_q == D_FULL);

  // D_TWO kept for readability of the depth threshold constants
  logic unused_two;
  assign unused_two = ^D_TWO;
endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack (WIDTH=35, DEPTH=16).
// Guard-specific expectations follow PARAM_STACK_GUARD_EN.
module tb_param_stack;
  localparam int W  = 35;
  localparam int DL = 4;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  param_stack_if #(.WIDTH(W), .DEPTH_LOG2(DL)) bus ();

  param_stack #(.WIDTH(W), .DEPTH_LOG2(DL)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic push, input int k, input logic [W-1:0] data);
    bus.op_valid   = 1'b1;
    bus.op_push    = push;
    bus.op_pop_cnt = DL'(k);
    bus.op_data    = data;
    tick();
    bus.op_valid   = 1'b0;
    bus.op_push    = 1'b0;
    bus.op_pop_cnt = '0;
    bus.op_data    = '0;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.op_valid   = 1'b0;
    bus.op_push    = 1'b0;
    bus.op_pop_cnt = '0;
    bus.op_data    = '0;
    rst_b = 1'b0;
    #3;
    check("rst_depth", 64'(bus.depth), 64'd0);
    check("rst_top0", 64'(bus.top_0), 64'd0);
    check("rst_top1", 64'(bus.top_1), 64'd0);
    check("rst_ready", 64'(bus.op_ready), 64'd1);
    check("rst_empty", 64'(bus.empty), 64'd1);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_errs", 64'({bus.err_ovf, bus.err_udf}), 64'd0);
    @(negedge clk);
    rst_b = 1'b1;
    tick();

    // Back-to-back pushes 1,2,3
    for (int i = 1; i <= 3; i++) begin
      check("push_ready", 64'(bus.op_ready), 64'd1);
      op(1'b1, 0, W'(i));
    end
    check("p3_ready", 64'(bus.op_ready), 64'd1);
    check("p3_top0", 64'(bus.top_0), 64'h3);
    check("p3_top1", 64'(bus.top_1), 64'h2);
    check("p3_depth", 64'(bus.depth), 64'd3);
    check("p3_empty", 64'(bus.empty), 64'd0);

    // Pop 1: one fill cycle
    op(1'b0, 1, '0);
    check("pop1_ready_low", 64'(bus.op_ready), 64'd0);
    check("pop1_depth_early", 64'(bus.depth), 64'd2);
    tick();
    check("pop1_ready", 64'(bus.op_ready), 64'd1);
    check("pop1_top0", 64'(bus.top_0), 64'h2);
    check("pop1_top1", 64'(bus.top_1), 64'h1);

    // Push A..E, then pop 3 with push 0x55
    do_reset();
    for (int i = 0; i < 5; i++) op(1'b1, 0, W'(32'hA + i));
    check("ae_top0", 64'(bus.top_0), 64'hE);
    check("ae_depth", 64'(bus.depth), 64'd5);
    op(1'b1, 3, W'(32'h55));
    check("pp_ready_low", 64'(bus.op_ready), 64'd0);
    check("pp_depth", 64'(bus.depth), 64'd3);
    tick();
    check("pp_ready", 64'(bus.op_ready), 64'd1);
    check("pp_top0", 64'(bus.top_0), 64'h55);
    check("pp_top1", 64'(bus.top_1), 64'hB);

    // Push A..E, pop 2 without push: two fill cycles
    do_reset();
    for (int i = 0; i < 5; i++) op(1'b1, 0, W'(32'hA + i));
    op(1'b0, 2, '0);
    check("p2_ready_low0", 64'(bus.op_ready), 64'd0);
    check("p2_depth", 64'(bus.depth), 64'd3);
    tick();
    check("p2_ready_low1", 64'(bus.op_ready), 64'd0);
    check("p2_mid_top0", 64'(bus.top_0), 64'hC);
    tick();
    check("p2_ready", 64'(bus.op_ready), 64'd1);
    check("p2_top0", 64'(bus.top_0), 64'hC);
    check("p2_top1", 64'(bus.top_1), 64'hB);

    // Depth 3 (A,B,C), pop 2 -> nd=1: single fill, top_1 zero
    op(1'b0, 2, '0);
    check("p2n1_ready_low", 64'(bus.op_ready), 64'd0);
    tick();
    check("p2n1_ready", 64'(bus.op_ready), 64'd1);
    check("p2n1_top0", 64'(bus.top_0), 64'hA);
    check("p2n1_top1", 64'(bus.top_1), 64'h0);
    check("p2n1_depth", 64'(bus.depth), 64'd1);

    // Depth 2 (A,0x77), pop 2 -> nd=0: no fill
    op(1'b1, 0, W'(32'h77));
    check("x_top1", 64'(bus.top_1), 64'hA);
    op(1'b0, 2, '0);
    check("p2n0_ready", 64'(bus.op_ready), 64'd1);
    check("p2n0_tops", 64'({bus.top_0, bus.top_1}), 64'd0);
    check("p2n0_empty", 64'(bus.empty), 64'd1);

    // Reset asserted during FILL1
    for (int i = 0; i < 5; i++) op(1'b1, 0, W'(32'hA + i));
    op(1'b0, 2, '0);
    tick();
    check("rf_in_fill1", 64'(bus.op_ready), 64'd0);
    rst_b = 1'b0;
    #1;
    check("rf_depth", 64'(bus.depth), 64'd0);
    check("rf_tops", 64'({bus.top_0, bus.top_1}), 64'd0);
    check("rf_ready", 64'(bus.op_ready), 64'd1);
    rst_b = 1'b1;
    tick();

`ifdef PARAM_STACK_GUARD_EN
    // Underflow at depth 0
    op(1'b0, 1, '0);
    check("udf_err", 64'(bus.err_udf), 64'd1);
    check("udf_depth", 64'(bus.depth), 64'd0);
    check("udf_ready", 64'(bus.op_ready), 64'd1);
    for (int i = 1; i <= 16; i++) op(1'b1, 0, W'(i));
    check("fill_full", 64'(bus.full), 64'd1);
    op(1'b1, 0, W'(32'h99));
    check("ovf_err", 64'(bus.err_ovf), 64'd1);
    check("ovf_full", 64'(bus.full), 64'd1);
    check("ovf_depth", 64'(bus.depth), 64'd16);
    check("ovf_top0", 64'(bus.top_0), 64'h10);
    check("ovf_top1", 64'(bus.top_1), 64'hF);
    check("udf_sticky", 64'(bus.err_udf), 64'd1);
`else
    // Wrapped push-with-pop at depth 0: nd=0
    op(1'b1, 1, W'(32'h7));
    check("wrap_depth", 64'(bus.depth), 64'd0);
    check("wrap_tops", 64'({bus.top_0, bus.top_1}), 64'd0);
    check("wrap_errs", 64'({bus.err_ovf, bus.err_udf}), 64'd0);
    check("wrap_ready", 64'(bus.op_ready), 64'd1);
    check("wrap_empty", 64'(bus.empty), 64'd1);
    // Legacy overflow: depth keeps counting past DEPTH
    do_reset();
    for (int i = 1; i <= 16; i++) op(1'b1, 0, W'(i));
    check("fill_full", 64'(bus.full), 64'd1);
    op(1'b1, 0, W'(32'h11));
    check("lovf_depth", 64'(bus.depth), 64'd17);
    check("lovf_full", 64'(bus.full), 64'd0);
    check("lovf_top0", 64'(bus.top_0), 64'h11);
    check("lovf_top1", 64'(bus.top_1), 64'h10);
    check("lovf_errs", 64'({bus.err_ovf, bus.err_udf}), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
